mac_sequencer: RTL and testbench

Controller that computes an N×N matrix product C = A·B on a single shared 4-bit MAC datapath (multiplier plus 8-bit accumulator). It holds local A, B and C register files and sequences operand feeding, accumulator clear/load and result capture for every output element. Software-side logic loads A and B, pulses `start`, waits for `done`, then reads C.

---
 rtl/mac_sequencer_if.sv | 31 +++
 rtl/mac_sequencer.sv | 115 +++++++++++
 tb/tb_mac_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_sequencer_if.sv
// Host and MAC-side signals of the matrix-product sequencer.
// master = software/MAC environment, slave = sequencer.
interface mac_sequencer_if #(
    parameter int DW = 4,
    parameter int AW = 8
);
    logic          start;
    logic          busy;
    logic          done;
    logic          wr_en;
    logic          wr_sel;
    logic [3:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    rd_addr;
    logic [AW-1:0] rd_data;
    logic [DW-1:0] mac_w;
    logic [DW-1:0] mac_x;
    logic          mac_load;
    logic          mac_clear;
    logic [AW-1:0] mac_o;

    modport master (
        output start, wr_en, wr_sel, wr_addr, wr_data, rd_addr, mac_o,
        input  busy, done, rd_data, mac_w, mac_x, mac_load, mac_clear
    );

    modport slave (
        input  start, wr_en, wr_sel, wr_addr, wr_data, rd_addr, mac_o,
        output busy, done, rd_data, mac_w, mac_x, mac_load, mac_clear
    );
endinterface

// File: rtl/mac_sequencer.sv
// Sequences an NxN matrix product C = A*B onto one external MAC
// (registered multiplier, falling-edge accumulator).
module mac_sequencer #(
    parameter int N  = 2,
    parameter int DW = 4,
    parameter int AW = 8
) (
    input  logic            clk,
    input  logic            clr_n,
    mac_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    localparam logic [1:0] LAST = 2'(N - 1);

    state_t        state, state_nx;
    logic [1:0]    i, j, k;
    logic [1:0]    i_nx, j_nx, k_nx;
    logic          ld_q;
    logic          wr_ok;

    logic [DW-1:0] a_rf [16];
    logic [DW-1:0] b_rf [16];
    logic [AW-1:0] c_rf [16];

    always_comb begin
        state_nx = state;
        i_nx     = i;
        j_nx     = j;
        k_nx     = k;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = CLEAR;
                    i_nx     = 2'd0;
                    j_nx     = 2'd0;
                    k_nx     = 2'd0;
                end
            end
            CLEAR: begin
                state_nx = FEED;
                k_nx     = 2'd0;
            end
            FEED: begin
                if (k == LAST) begin
                    state_nx = DRAIN;
                    k_nx     = 2'd0;
                end else begin
                    k_nx = k + 2'd1;
                end
            end
            DRAIN: begin
                state_nx = CLEAR;
                if (j == LAST) begin
                    j_nx = 2'd0;
                    if (i == LAST) begin
                        state_nx = DONE;
                        i_nx     = 2'd0;
                    end else begin
                        i_nx = i + 2'd1;
                    end
                end else begin
                    j_nx = j + 2'd1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ld_q trails FEED by one cycle so the MAC adds each product the
    // cycle after its operands were presented.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state <= IDLE;
            i     <= 2'd0;
            j     <= 2'd0;
            k     <= 2'd0;
            ld_q  <= 1'b0;
        end else begin
            state <= state_nx;
            i     <= i_nx;
            j     <= j_nx;
            k     <= k_nx;
            ld_q  <= (state == FEED);
        end
    end

    assign wr_ok = bus.wr_en && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int n = 0; n < 16; n++) begin
                a_rf[n] <= '0;
                b_rf[n] <= '0;
                c_rf[n] <= '0;
            end
        end else begin
            if (wr_ok) begin
                if (bus.wr_sel) b_rf[bus.wr_addr] <= bus.wr_data;
                else            a_rf[bus.wr_addr] <= bus.wr_data;
            end
            // Accumulator holds the complete sum by the end of DRAIN.
            if (state == DRAIN) c_rf[{i, j}] <= bus.mac_o;
        end
    end

    assign bus.busy      = (state == CLEAR) || (state == FEED) || (state == DRAIN);
    assign bus.done      = (state == DONE);
    assign bus.mac_clear = (state == IDLE) || (state == CLEAR);
    assign bus.mac_load  = ld_q;
    assign bus.mac_w     = (state == FEED) ? a_rf[{i, k}] : '0;
    assign bus.mac_x     = (state == FEED) ? b_rf[{k, j}] : '0;
    assign bus.rd_data   = c_rf[bus.rd_addr];
endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: N=2 and N=3 instances, each with a MAC model,
// a cycle-count reference model and directed literal checks.
module tb_mac_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr_n;
    logic       wr_en, wr_sel;
    logic [3:0] wr_addr, wr_data, rd_addr;
    logic       start2, start3;
    logic       chk_en;

    int n_chk  = 0;
    int n_fail = 0;
    int bc2 = 0, dc2 = 0, bc3 = 0, dc3 = 0;
    logic [4:0] lp3;

    mac_sequencer_if #(.DW(4), .AW(8)) if2 ();
    mac_sequencer_if #(.DW(4), .AW(8)) if3 ();

    assign if2.start   = start2;
    assign if3.start   = start3;
    assign if2.wr_en   = wr_en;   assign if3.wr_en   = wr_en;
    assign if2.wr_sel  = wr_sel;  assign if3.wr_sel  = wr_sel;
    assign if2.wr_addr = wr_addr; assign if3.wr_addr = wr_addr;
    assign if2.wr_data = wr_data; assign if3.wr_data = wr_data;
    assign if2.rd_addr = rd_addr; assign if3.rd_addr = rd_addr;

    mac_sequencer #(.N(2), .DW(4), .AW(8)) dut2 (.clk(clk), .clr_n(clr_n), .bus(if2.slave));
    mac_sequencer #(.N(3), .DW(4), .AW(8)) dut3 (.clk(clk), .clr_n(clr_n), .bus(if3.slave));

    // MAC models: product registered on rising edge, accumulate/clear on falling edge.
    logic [7:0] prod2, acc2, prod3, acc3;
    always @(posedge clk) prod2 <= {4'b0, if2.mac_w} * {4'b0, if2.mac_x};
    always @(posedge clk) prod3 <= {4'b0, if3.mac_w} * {4'b0, if3.mac_x};
    always @(negedge clk) begin
        if (if2.mac_clear)     acc2 <= 8'd0;
        else if (if2.mac_load) acc2 <= acc2 + prod2;
    end
    always @(negedge clk) begin
        if (if3.mac_clear)     acc3 <= 8'd0;
        else if (if3.mac_load) acc3 <= acc3 + prod3;
    end
    assign if2.mac_o = acc2;
    assign if3.mac_o = acc3;

    logic       dbusy [2], ddone [2], dload [2], dclr [2];
    logic [3:0] dw [2], dx [2];
    logic [7:0] drd [2];
    assign dbusy[0] = if2.busy;      assign dbusy[1] = if3.busy;
    assign ddone[0] = if2.done;      assign ddone[1] = if3.done;
    assign dload[0] = if2.mac_load;  assign dload[1] = if3.mac_load;
    assign dclr[0]  = if2.mac_clear; assign dclr[1]  = if3.mac_clear;
    assign dw[0]    = if2.mac_w;     assign dw[1]    = if3.mac_w;
    assign dx[0]    = if2.mac_x;     assign dx[1]    = if3.mac_x;
    assign drd[0]   = if2.rd_data;   assign drd[1]   = if3.rd_data;

    // Reference model: job position as a cycle count (0 idle, 1..T busy, T+1 done).
    int         m_cnt [2];
    logic [3:0] mA [2][16];
    logic [3:0] mB [2][16];
    logic [7:0] mC [2][16];

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            int nn, tt, e, s;
            logic st;
            nn = (u == 0) ? 2 : 3;
            tt = nn * nn * (nn + 2);
            st = (u == 0) ? start2 : start3;
            if (!clr_n) begin
                m_cnt[u] = 0;
                for (int a = 0; a < 16; a++) begin
                    mA[u][a] = 4'd0; mB[u][a] = 4'd0; mC[u][a] = 8'd0;
                end
            end else begin
                if ((m_cnt[u] == 0 || m_cnt[u] == tt + 1) && wr_en) begin
                    if (wr_sel) mB[u][wr_addr] = wr_data;
                    else        mA[u][wr_addr] = wr_data;
                end
                if (m_cnt[u] >= 1 && m_cnt[u] <= tt && (m_cnt[u] % (nn + 2)) == 0) begin
                    e = m_cnt[u] / (nn + 2) - 1;
                    s = 0;
                    for (int kk = 0; kk < nn; kk++)
                        s += int'(mA[u][(e / nn) * 4 + kk]) * int'(mB[u][kk * 4 + (e % nn)]);
                    mC[u][(e / nn) * 4 + (e % nn)] = 8'(s);
                end
                if (m_cnt[u] == 0)           m_cnt[u] = st ? 1 : 0;
                else if (m_cnt[u] == tt + 1) m_cnt[u] = 0;
                else                         m_cnt[u] = m_cnt[u] + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            for (int u = 0; u < 2; u++) begin
                int nn, tt, cnt, p, e, kk;
                logic bz;
                logic [3:0] we, xe;
                nn  = (u == 0) ? 2 : 3;
                tt  = nn * nn * (nn + 2);
                cnt = m_cnt[u];
                bz  = (cnt >= 1 && cnt <= tt);
                p   = bz ? (cnt - 1) % (nn + 2) : 0;
                e   = bz ? (cnt - 1) / (nn + 2) : 0;
                kk  = p - 1;
                we  = 4'd0;
                xe  = 4'd0;
                if (bz && p >= 1 && p <= nn) begin
                    we = mA[u][(e / nn) * 4 + kk];
                    xe = mB[u][kk * 4 + (e % nn)];
                end
                chk(u ? "busy3" : "busy2", 32'(dbusy[u]), 32'(bz));
                chk(u ? "done3" : "done2", 32'(ddone[u]), 32'(cnt == tt + 1));
                chk(u ? "load3" : "load2", 32'(dload[u]), 32'(bz && p >= 2));
                chk(u ? "clear3" : "clear2", 32'(dclr[u]), 32'(cnt == 0 || (bz && p == 0)));
                chk(u ? "mac_w3" : "mac_w2", 32'(dw[u]), 32'(we));
                chk(u ? "mac_x3" : "mac_x2", 32'(dx[u]), 32'(xe));
                chk(u ? "rd3" : "rd2", 32'(drd[u]), 32'(mC[u][rd_addr]));
            end
            if (if3.busy && bc3 < 5) lp3[bc3] = if3.mac_load;
            if (if2.busy) bc2++;
            if (if2.done) dc2++;
            if (if3.busy) bc3++;
            if (if3.done) dc3++;
        end
    end

    task automatic wr(input logic sel, input logic [3:0] a, input logic [3:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic load2(input logic sel, input logic [3:0] v00, v01, v10, v11);
        wr(sel, 4'd0, v00); wr(sel, 4'd1, v01);
        wr(sel, 4'd4, v10); wr(sel, 4'd5, v11);
    endtask

    task automatic wait_done(input int u, input int budget);
        int t;
        t = 0;
        do begin
            @(posedge clk); #1;
            t++;
        end while (!(u ? if3.done : if2.done) && t < budget);
        chk(u ? "done3_timeout" : "done2_timeout", 32'(t < budget), 32'd1);
    endtask

    task automatic run(input int u, input int budget);
        @(negedge clk);
        if (u) start3 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; start3 = 1'b0;
        wait_done(u, budget);
    endtask

    task automatic rd_lit(input int u, input logic [3:0] a, input logic [7:0] exp, input string nm);
        @(negedge clk);
        rd_addr = a;
        #1 chk(nm, 32'(u ? if3.rd_data : if2.rd_data), 32'(exp));
    endtask

    initial begin
        logic [3:0] b9 [9];
        clr_n = 1'b0; chk_en = 1'b0;
        wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 4'd0; rd_addr = 4'd0;
        start2 = 1'b0; start3 = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 32'(if2.busy), 32'd0);
        chk("rst_clear", 32'(if2.mac_clear), 32'd1);
        chk("rst_load", 32'(if2.mac_load), 32'd0);
        clr_n = 1'b1;
        rd_lit(0, 4'd5, 8'd0, "rst_c11");

        // basic product
        load2(1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
        load2(1'b1, 4'd5, 4'd6, 4'd7, 4'd8);
        bc2 = 0; dc2 = 0;
        run(0, 40);
        rd_lit(0, 4'd0, 8'd19, "basic_c00");
        rd_lit(0, 4'd1, 8'd22, "basic_c01");
        rd_lit(0, 4'd4, 8'd43, "basic_c10");
        rd_lit(0, 4'd5, 8'd50, "basic_c11");
        chk("basic_busy_cycles", 32'(bc2), 32'd16);
        chk("basic_done_pulses", 32'(dc2), 32'd1);

        // writes and start during busy are dropped
        bc2 = 0; dc2 = 0;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        repeat (3) @(negedge clk);
        wr(1'b1, 4'd0, 4'd9);
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        wait_done(0, 40);
        repeat (25) @(negedge clk);
        chk("ign_busy_cycles", 32'(bc2), 32'd16);
        chk("ign_done_pulses", 32'(dc2), 32'd1);
        rd_lit(0, 4'd0, 8'd19, "ign_c00");
        rd_lit(0, 4'd5, 8'd50, "ign_c11");
        run(0, 40);
        rd_lit(0, 4'd0, 8'd19, "ign_rerun_c00");

        // accumulator wrap
        load2(1'b0, 4'd15, 4'd15, 4'd15, 4'd15);
        load2(1'b1, 4'd15, 4'd15, 4'd15, 4'd15);
        run(0, 40);
        rd_lit(0, 4'd0, 8'hC2, "wrap_c00");
        rd_lit(0, 4'd1, 8'hC2, "wrap_c01");
        rd_lit(0, 4'd4, 8'hC2, "wrap_c10");
        rd_lit(0, 4'd5, 8'hC2, "wrap_c11");

        // reset at busy cycle 7
        dc2 = 0;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        repeat (6) @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        chk("midrst_busy", 32'(if2.busy), 32'd0);
        chk("midrst_clear", 32'(if2.mac_clear), 32'd1);
        rd_lit(0, 4'd0, 8'd0, "midrst_c00");
        rd_lit(0, 4'd1, 8'd0, "midrst_c01");
        rd_lit(0, 4'd4, 8'd0, "midrst_c10");
        rd_lit(0, 4'd5, 8'd0, "midrst_c11");
        repeat (20) @(negedge clk);
        chk("midrst_no_done", 32'(dc2), 32'd0);

        // identity, N=3
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                b9[r * 3 + c] = 4'(r * 3 + c + 1);
                wr(1'b0, 4'(r * 4 + c), (r == c) ? 4'd1 : 4'd0);
                wr(1'b1, 4'(r * 4 + c), b9[r * 3 + c]);
            end
        bc3 = 0; dc3 = 0;
        run(1, 100);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                rd_lit(1, 4'(r * 4 + c), {4'd0, b9[r * 3 + c]}, "ident_c");
        chk("ident_busy_cycles", 32'(bc3), 32'd45);
        chk("ident_done_pulses", 32'(dc3), 32'd1);
        chk("ident_load_pattern", 32'(lp3), 32'b11100);

        // start held through DONE, then released: no extra job
        load2(1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
        load2(1'b1, 4'd5, 4'd6, 4'd7, 4'd8);
        dc2 = 0;
        @(negedge clk); start2 = 1'b1;
        wait_done(0, 40);
        @(negedge clk);
        @(negedge clk); start2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_no_rerun", 32'(if2.busy), 32'd0);
        chk("held_done_pulses", 32'(dc2), 32'd1);

        // back-to-back: new B written in DONE, start one cycle after done
        run(0, 40);
        bc2 = 0;
        @(negedge clk);
        wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd0; wr_data = 4'd2; start2 = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        chk("b2b_idle_gap", 32'(if2.busy), 32'd0);
        @(negedge clk); start2 = 1'b0;
        chk("b2b_started", 32'(if2.busy), 32'd1);
        wait_done(0, 40);
        rd_lit(0, 4'd0, 8'd16, "b2b_c00");
        rd_lit(0, 4'd1, 8'd22, "b2b_c01");
        rd_lit(0, 4'd4, 8'd34, "b2b_c10");
        rd_lit(0, 4'd5, 8'd50, "b2b_c11");
        chk("b2b_busy_cycles", 32'(bc2), 32'd16);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
